// File: rtl/cfu_mac_pkg.sv
// cfu_mac_pkg: shared definitions for the CFU MAC sequencer.
// It holds the funct3 opcodes, the controller state enum and the default activation offset.
package cfu_mac_pkg;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_SETLEN = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_MAC    = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;

  localparam int DEFAULT_INPUT_OFFSET = 128;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    RESP
  } state_e;

endpackage

// File: rtl/cfu_simd_dot4.sv
// cfu_simd_dot4: registered 4-lane int8 offset-multiply with an adder tree.
//   clk, reset      : clock and synchronous active-high reset
//   load_i          : capture the activation and filter words
//   mul_i           : register the four lane products
//   act_i, filt_i   : packed int8 activation and filter words
//   sum_o           : sign-extended sum of the registered products
module cfu_simd_dot4 #(
  parameter int INPUT_OFFSET = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        mul_i,
  input  logic [31:0] act_i,
  input  logic [31:0] filt_i,
  output logic [31:0] sum_o
);

  logic        [31:0] act_q;
  logic        [31:0] wgt_q;
  logic signed [16:0] prod_q [4];
  logic signed [16:0] prod_d [4];
  logic signed [8:0]  a_lane [4];
  logic signed [7:0]  w_lane [4];
  logic signed [18:0] sum;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      a_lane[i] = 9'(signed'(act_q[8*i +: 8])) + 9'(INPUT_OFFSET);
      w_lane[i] = signed'(wgt_q[8*i +: 8]);
      prod_d[i] = 17'(a_lane[i]) * 17'(w_lane[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q <= '0;
      wgt_q <= '0;
      for (int unsigned i = 0; i < 4; i++) prod_q[i] <= '0;
    end else begin
      if (load_i) begin
        act_q <= act_i;
        wgt_q <= filt_i;
      end
      if (mul_i) begin
        for (int unsigned i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    sum   = 19'(prod_q[0]) + 19'(prod_q[1]) + 19'(prod_q[2]) + 19'(prod_q[3]);
    sum_o = 32'(sum);
  end

endmodule

// File: rtl/cfu_mac_sequencer.sv
// cfu_mac_sequencer: CFU controller that owns a packed int8 filter bank and sequences
// a 4-lane SIMD MAC. It also holds the accumulator, the auto-wrapping filter pointer and the loop length.
//   clk, reset                 : clock and synchronous active-high reset
//   cmd_valid / cmd_ready      : command handshake (ready only in IDLE)
//   cmd_payload_function_id    : [9:3] funct7, [2:0] funct3 opcode
//   cmd_payload_inputs_0/1     : operand / filter index
//   rsp_valid / rsp_ready      : response handshake
//   rsp_payload_outputs_0      : response data
// Build option CFU_MAC_SAT_EN: the accumulator saturates instead of wrapping.
module cfu_mac_sequencer
  import cfu_mac_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int          INPUT_OFFSET = DEFAULT_INPUT_OFFSET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_e          state_q, state_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     rsp_q, rsp_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [31:0]     filt_q [DEPTH];

  logic            accept;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [LW-1:0]   setlen_val;
  logic            wr_en;
  logic            mac_load;
  logic            mac_mul;
  logic [31:0]     dot_sum;
  logic [31:0]     acc_next;

  assign funct7 = cmd_payload_function_id[9:3];
  assign funct3 = cmd_payload_function_id[2:0];
  assign accept = cmd_valid && (state_q == IDLE);

  always_comb begin
    if (cmd_payload_inputs_0 == '0 || cmd_payload_inputs_0 > 32'(DEPTH)) begin
      setlen_val = LW'(DEPTH);
    end else begin
      setlen_val = LW'(cmd_payload_inputs_0);
    end
  end

`ifdef CFU_MAC_SAT_EN
  logic [32:0] acc_wide;
  always_comb begin
    acc_wide = {acc_q[31], acc_q} + {dot_sum[31], dot_sum};
    if (acc_wide[32] != acc_wide[31]) begin
      acc_next = acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      acc_next = acc_wide[31:0];
    end
  end
`else
  assign acc_next = acc_q + dot_sum;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rsp_d    = rsp_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    wr_en    = 1'b0;
    mac_load = 1'b0;
    mac_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          rsp_d   = '0;
          if (funct7 == '0) begin
            case (funct3)
              OP_CLEAR: begin
                acc_d = '0;
                ptr_d = '0;
              end
              OP_SETLEN: begin
                len_d = setlen_val;
                // keep ptr inside the new loop so the MAC wrap compare stays reachable
                if ({1'b0, ptr_q} >= setlen_val) ptr_d = '0;
                rsp_d = 32'(setlen_val);
              end
              OP_WRITE: begin
                wr_en = (cmd_payload_inputs_1 < 32'(DEPTH));
              end
              OP_MAC: begin
                mac_load = 1'b1;
                state_d  = MUL;
              end
              OP_READ: begin
                rsp_d = acc_q;
              end
              default: begin
                rsp_d = '0;
              end
            endcase
          end
        end
      end
      MUL: begin
        mac_mul = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        acc_d   = acc_next;
        rsp_d   = acc_next;
        ptr_d   = ({1'b0, ptr_q} == len_q - LW'(1)) ? '0 : ptr_q + AW'(1);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rsp_q   <= '0;
      ptr_q   <= '0;
      len_q   <= LW'(DEPTH);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) filt_q[i] <= '0;
    end else if (wr_en) begin
      filt_q[cmd_payload_inputs_1[AW-1:0]] <= cmd_payload_inputs_0;
    end
  end

  cfu_simd_dot4 #(
    .INPUT_OFFSET(INPUT_OFFSET)
  ) u_dot4 (
    .clk    (clk),
    .reset  (reset),
    .load_i (mac_load),
    .mul_i  (mac_mul),
    .act_i  (cmd_payload_inputs_0),
    .filt_i (filt_q[ptr_q]),
    .sum_o  (dot_sum)
  );

  assign cmd_ready             = (state_q == IDLE);
  assign rsp_valid             = (state_q == RESP);
  assign rsp_payload_outputs_0 = rsp_q;

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
module tb_cfu_mac_sequencer;

  localparam int DEPTH = 16;
  localparam int OFF   = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_payload_outputs_0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cfu_mac_sequencer #(
    .DEPTH(DEPTH),
    .INPUT_OFFSET(OFF)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  // Reference model: plain integer arithmetic on the command rules.
  int          m_acc;
  int          m_ptr;
  int          m_len;
  logic [31:0] m_filt [DEPTH];

  function automatic void model_reset();
    m_acc = 0;
    m_ptr = 0;
    m_len = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_filt[i] = '0;
  endfunction

  function automatic void model_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                                    output logic [31:0] exp_rsp, output int exp_lat);
    logic [31:0] w;
    longint      t;
    int          s;
    int          a;
    int          f;
    exp_rsp = '0;
    exp_lat = 1;
    if (fid[9:3] != 0) return;
    case (fid[2:0])
      3'd0: begin m_acc = 0; m_ptr = 0; end
      3'd1: begin
        m_len = (in0 == 0 || in0 > DEPTH) ? DEPTH : int'(in0);
        if (m_ptr >= m_len) m_ptr = 0;
        exp_rsp = m_len;
      end
      3'd2: if (in1 < DEPTH) m_filt[in1] = in0;
      3'd3: begin
        w = m_filt[m_ptr];
        s = 0;
        for (int i = 0; i < 4; i++) begin
          a = int'($signed(in0[8*i +: 8])) + OFF;
          f = int'($signed(w[8*i +: 8]));
          s += a * f;
        end
        t = longint'(m_acc) + longint'(s);
`ifdef CFU_MAC_SAT_EN
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
        m_acc   = int'(t);
        m_ptr   = (m_ptr == m_len - 1) ? 0 : m_ptr + 1;
        exp_rsp = m_acc;
        exp_lat = 3;
      end
      3'd4: exp_rsp = m_acc;
      default: exp_rsp = '0;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] rsp, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_ready_timeout: got 0, want 1");
    end
    cmd_valid               = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: got no rsp_valid, want rsp_valid");
    end
    rsp = rsp_payload_outputs_0;
    @(posedge clk);
  endtask

  task automatic run(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] rsp, output int lat, output logic [31:0] exp_rsp, output int exp_lat);
    model_cmd(fid, a, b, exp_rsp, exp_lat);
    send(fid, a, b, rsp, lat);
  endtask

  typedef struct {
    string       name;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e, input int l);
    vec_t v;
    v.name = n; v.fid = f; v.in0 = a; v.in1 = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  initial begin
    logic [31:0] rsp, exp_rsp;
    int          lat, exp_lat;
    logic [9:0]  fid;
    logic [31:0] a, b;
    int          eff;

    tbl.push_back(mk("read_after_reset", 10'd4, 32'h0, 32'h0, 32'h0000_0000, 1));
    tbl.push_back(mk("setlen0",          10'd1, 32'h0, 32'h0, 32'd16, 1));
    tbl.push_back(mk("write_f0",         10'd2, 32'h0101_0101, 32'd0, 32'h0, 1));
    tbl.push_back(mk("setlen1",          10'd1, 32'd1, 32'h0, 32'd1, 1));
    tbl.push_back(mk("mac_first",        10'd3, 32'h0, 32'h0, 32'h0000_0200, 3));
    tbl.push_back(mk("mac_wrap",         10'd3, 32'h0, 32'h0, 32'h0000_0400, 3));
    tbl.push_back(mk("clear",            10'd0, 32'h0, 32'h0, 32'h0, 1));
    tbl.push_back(mk("write_f0b",        10'd2, 32'h0202_0202, 32'd0, 32'h0, 1));
    tbl.push_back(mk("write_f1",         10'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1));
    tbl.push_back(mk("setlen2",          10'd1, 32'd2, 32'h0, 32'd2, 1));
    tbl.push_back(mk("mac_zero_act",     10'd3, 32'h8080_8080, 32'h0, 32'h0000_0000, 3));
    tbl.push_back(mk("mac_neg",          10'd3, 32'h7F7F_7F7F, 32'h0, 32'hFFFF_FC04, 3));
    tbl.push_back(mk("write_oob",        10'd2, 32'hDEAD_BEEF, 32'd16, 32'h0, 1));
    tbl.push_back(mk("mac_f0_intact",    10'd3, 32'h8080_8080, 32'h0, 32'hFFFF_FC04, 3));
    tbl.push_back(mk("mac_f1_intact",    10'd3, 32'h0101_0101, 32'h0, 32'hFFFF_FA00, 3));
    tbl.push_back(mk("funct7_nonzero",   {7'd1, 3'd4}, 32'h0, 32'h0, 32'h0, 1));
    tbl.push_back(mk("op5",              10'd5, 32'h1234_5678, 32'h0, 32'h0, 1));
    tbl.push_back(mk("op7",              10'd7, 32'h1234_5678, 32'h0, 32'h0, 1));
    tbl.push_back(mk("setlen_big",       10'd1, 32'd17, 32'h0, 32'd16, 1));
    tbl.push_back(mk("read_acc",         10'd4, 32'h0, 32'h0, 32'hFFFF_FA00, 1));

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check32("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("reset_rsp_data", rsp_payload_outputs_0, 32'h0);

    foreach (tbl[i]) begin
      run(tbl[i].fid, tbl[i].in0, tbl[i].in1, rsp, lat, exp_rsp, exp_lat);
      check32(tbl[i].name, rsp, tbl[i].exp);
      check32({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].lat));
    end

    // rsp_ready held low while a second command is offered
    model_cmd(10'd4, 32'h0, 32'h0, exp_rsp, exp_lat);
    @(negedge clk);
    rsp_ready               = 1'b0;
    cmd_valid               = 1'b1;
    cmd_payload_function_id = 10'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_payload_function_id = 10'd3;
    cmd_payload_inputs_0    = 32'h7F7F_7F7F;
    for (int c = 0; c < 5; c++) begin
      check32("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check32("hold_rsp_data", rsp_payload_outputs_0, exp_rsp);
      check32("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      if (c < 4) @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    run(10'd4, 32'h0, 32'h0, rsp, lat, exp_rsp, exp_lat);
    check32("hold_acc_unchanged", rsp, 32'hFFFF_FA00);

    // randomized commands against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       fid = 10'd0;
        1, 2:    fid = 10'd1;
        3, 4:    fid = 10'd2;
        5, 6, 7: fid = 10'd3;
        8:       fid = 10'd4;
        default: fid = 10'($urandom_range(5, 7));
      endcase
      if ($urandom_range(0, 15) == 0) fid[9:3] = 7'($urandom_range(1, 127));
      a = $urandom();
      b = $urandom_range(0, DEPTH + 3);
      if (fid == 10'd1) begin
        a   = $urandom_range(0, DEPTH + 4);
        eff = (a == 0 || a > DEPTH) ? DEPTH : int'(a);
        if (eff == m_ptr && m_ptr != 0) a = DEPTH;
      end
      run(fid, a, b, rsp, lat, exp_rsp, exp_lat);
      check32("rand_rsp", rsp, exp_rsp);
      check32("rand_lat", 32'(lat), 32'(exp_lat));
    end

    // long accumulation into the overflow region
    run(10'd0, 32'h0, 32'h0, rsp, lat, exp_rsp, exp_lat);
    run(10'd2, 32'h7F7F_7F7F, 32'd0, rsp, lat, exp_rsp, exp_lat);
    run(10'd1, 32'd1, 32'h0, rsp, lat, exp_rsp, exp_lat);
    for (int n = 0; n < 16578; n++) begin
      run(10'd3, 32'h7F7F_7F7F, 32'h0, rsp, lat, exp_rsp, exp_lat);
    end
`ifdef CFU_MAC_SAT_EN
    check32("long_mac_final", rsp, 32'h7FFF_FFFF);
`else
    check32("long_mac_final", rsp, 32'h8000_7708);
`endif

    // reset while a MAC sits in MUL
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = 10'd3;
    cmd_payload_inputs_0    = 32'h7F7F_7F7F;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      check32("abort_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    run(10'd4, 32'h0, 32'h0, rsp, lat, exp_rsp, exp_lat);
    check32("post_reset_read", rsp, 32'h0);
    run(10'd1, 32'h0, 32'h0, rsp, lat, exp_rsp, exp_lat);
    check32("post_reset_len", rsp, 32'd16);
    run(10'd3, 32'h0, 32'h0, rsp, lat, exp_rsp, exp_lat);
    check32("post_reset_mac", rsp, 32'h0);
    check32("post_reset_mac_lat", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
